dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port memory bus between instruction fetch (I-port) and the MEMORY stage (D-port).
//  Loads stall the requester until data returns. Stores are posted into a 1-entry write buffer.
//  The write buffer drains ahead of any read, so a load never sees stale data.
//  Sits between the fetch/memory pipeline stages and the unified memory model.
// PARAMETERS
//  ADDR_W   32  address width (bus and both ports)
//  DATA_W   32  data width (bus and both ports)
// PORTS
//  clk            in   1       clock, all state on posedge
//  reset          in   1       asynchronous, active-low; clears all state
//  imem_addr      in   ADDR_W  fetch address
//  imem_rd_enable in   1       fetch read request; held until imem_rd_ready
//  imem_rd_data   out  DATA_W  fetch data; valid while imem_rd_ready=1
//  imem_rd_ready  out  1       fetch read complete, 1-cycle pulse
//  mem_addr       in   ADDR_W  D-port address (load or store)
//  mem_rd_enable  in   1       load request; held until mem_rd_ready
//  mem_rd_data    out  DATA_W  load data; valid while mem_rd_ready=1
//  mem_rd_ready   out  1       load complete, 1-cycle pulse
//  mem_wr_enable  in   1       store strobe, 1 cycle; captures mem_addr/mem_wr_data/mem_wr_size
//  mem_wr_data    in   DATA_W  store data
//  mem_wr_size    in   2       00 byte, 01 half, 10 word
//  wbuf_full      out  1       write buffer occupied; MEMORY stage must stall its next store
//  wbuf_ovf       out  1       sticky: store strobed while buffer full and not draining
//  bus_addr       out  ADDR_W  memory bus address
//  bus_wr_data    out  DATA_W  memory bus write data
//  bus_wr_size    out  2       memory bus write size
//  bus_wr_enable  out  1       bus write request
//  bus_rd_enable  out  1       bus read request
//  bus_rd_data    in   DATA_W  bus read data
//  bus_ready      in   1       bus transaction done this cycle (read data valid, or write taken)
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, write buffer empty, wbuf_ovf=0, rr_last=I.
//  Reset may assert at any time. Any in-flight bus op is abandoned and the buffered store is dropped.
//  FSM states: IDLE, IREAD, DREAD, DWRITE. Bus outputs are registered from state and latched operands.
//  IDLE choice, evaluated every cycle:
//   1. If wbuf_full, go to DWRITE.
//   2. Else if mem_rd_enable, go to DREAD.
//   3. Else if imem_rd_enable, go to IREAD.
//   4. Else stay in IDLE.
//  On entering a state, latch the address. Hold bus_*_enable=1 for the whole state.
//  IREAD/DREAD: when bus_ready=1, pulse the matching *_rd_ready and pass bus_rd_data through
//   combinationally; then go to IDLE.
//   Ready is gated by the live request: if the requester dropped its request (flush), no ready pulse.
//   The bus op still completes and its data is discarded.
//  DWRITE: when bus_ready=1, clear the buffer and go to IDLE.
//  Latency: request at cycle N gives a bus request at N+1; with zero-wait memory, ready at N+1.
//   Minimum cost is 1 IDLE cycle between transactions.
//  Write buffer capture:
//   - A store captures when the buffer is empty, or in the same cycle it drains (DWRITE and bus_ready).
//   - Otherwise the store is dropped and wbuf_ovf sets; only reset clears wbuf_ovf.
//   - wbuf_full mirrors buffer occupancy and is registered.
//  Simultaneous store strobe and load request: the store is captured first; the load waits for DWRITE.
//  mem_wr_size=11 is treated as word.
//  An address change while a request is held is ignored until the next IDLE decision.
// CONFIGURATION
//  DMEM_ARB_RR_EN
//   Undefined: fixed priority, D read over I read. I can starve while D requests back-to-back.
//   Defined: round-robin between I and D reads via rr_last, updated on each read completion.
//   Writes keep top priority in both modes.
// TESTING
//  1. Zero-wait memory, imem_rd_enable only, addr 0x100 -> bus_rd_enable at cycle+1; imem_rd_ready
//     at cycle+1 with bus_rd_data.
//  2. Store 0xDEADBEEF to 0x40 (size 10) and load 0x40 in the same cycle -> DWRITE issues first;
//     then DREAD returns 0xDEADBEEF.
//  3. Both read requests held for 4 transactions -> fixed mode: D,D,D,D;
//     with DMEM_ARB_RR_EN: D,I,D,I.
//  4. Bus with 3 wait states, fetch request dropped after 1 cycle -> bus op completes;
//     imem_rd_ready stays 0; FSM back in IDLE.
//  5. Second store while wbuf_full and bus stalled -> wbuf_ovf=1 and first store preserved;
//     with a drain-cycle store, no overflow.
//  6. Reset asserted in DREAD mid-wait -> all outputs 0 asynchronously; state IDLE; buffer empty.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and the MEMORY stage, with a 1-entry posted write buffer.
// Define DMEM_ARB_RR_EN for round-robin between I and D reads (default: D reads win).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rd_enable,
    output logic [DATA_W-1:0] imem_rd_data,
    output logic              imem_rd_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_enable,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rd_ready,
    input  logic              mem_wr_enable,
    input  logic [DATA_W-1:0] mem_wr_data,
    input  logic [1:0]        mem_wr_size,
    output logic              wbuf_full,
    output logic              wbuf_ovf,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    output logic [1:0]        bus_wr_size,
    output logic              bus_wr_enable,
    output logic              bus_rd_enable,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_ready
);

    typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [DATA_W-1:0] bus_wr_data_reg, bus_wr_data_next;
    logic [1:0]        bus_wr_size_reg, bus_wr_size_next;
    logic              bus_wr_enable_reg, bus_wr_enable_next;
    logic              bus_rd_enable_reg, bus_rd_enable_next;
    logic              wbuf_full_reg, wbuf_full_next;
    logic [ADDR_W-1:0] wbuf_addr_reg, wbuf_addr_next;
    logic [DATA_W-1:0] wbuf_data_reg, wbuf_data_next;
    logic [1:0]        wbuf_size_reg, wbuf_size_next;
    logic              wbuf_ovf_reg, wbuf_ovf_next;

    logic       drain;
    logic       capture;
    logic       pick_d;
    logic [1:0] store_size;

    assign drain      = (state_reg == DWRITE) && bus_ready;
    assign capture    = mem_wr_enable && (!wbuf_full_reg || drain);
    assign store_size = (mem_wr_size == 2'b11) ? 2'b10 : mem_wr_size;

`ifdef DMEM_ARB_RR_EN
    logic rr_last_reg;  // 1 when the last completed read belonged to the D-port

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_last_reg <= 1'b0;
        else if ((state_reg == IREAD || state_reg == DREAD) && bus_ready)
            rr_last_reg <= (state_reg == DREAD);
    end

    assign pick_d = mem_rd_enable && (!imem_rd_enable || !rr_last_reg);
`else
    assign pick_d = mem_rd_enable;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_addr_reg      <= '0;
            bus_wr_data_reg   <= '0;
            bus_wr_size_reg   <= '0;
            bus_wr_enable_reg <= 1'b0;
            bus_rd_enable_reg <= 1'b0;
            wbuf_full_reg     <= 1'b0;
            wbuf_addr_reg     <= '0;
            wbuf_data_reg     <= '0;
            wbuf_size_reg     <= '0;
            wbuf_ovf_reg      <= 1'b0;
        end else begin
            bus_addr_reg      <= bus_addr_next;
            bus_wr_data_reg   <= bus_wr_data_next;
            bus_wr_size_reg   <= bus_wr_size_next;
            bus_wr_enable_reg <= bus_wr_enable_next;
            bus_rd_enable_reg <= bus_rd_enable_next;
            wbuf_full_reg     <= wbuf_full_next;
            wbuf_addr_reg     <= wbuf_addr_next;
            wbuf_data_reg     <= wbuf_data_next;
            wbuf_size_reg     <= wbuf_size_next;
            wbuf_ovf_reg      <= wbuf_ovf_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        bus_addr_next      = bus_addr_reg;
        bus_wr_data_next   = bus_wr_data_reg;
        bus_wr_size_next   = bus_wr_size_reg;
        bus_wr_enable_next = bus_wr_enable_reg;
        bus_rd_enable_next = bus_rd_enable_reg;
        wbuf_full_next     = wbuf_full_reg;
        wbuf_addr_next     = wbuf_addr_reg;
        wbuf_data_next     = wbuf_data_reg;
        wbuf_size_next     = wbuf_size_reg;
        wbuf_ovf_next      = wbuf_ovf_reg;

        if (drain)
            wbuf_full_next = 1'b0;
        if (capture) begin
            wbuf_full_next = 1'b1;
            wbuf_addr_next = mem_addr;
            wbuf_data_next = mem_wr_data;
            wbuf_size_next = store_size;
        end else if (mem_wr_enable) begin
            wbuf_ovf_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                // A store strobed this cycle is already headed for the buffer, so it beats a same-cycle load.
                if (wbuf_full_reg || mem_wr_enable) begin
                    state_next         = DWRITE;
                    bus_wr_enable_next = 1'b1;
                    if (wbuf_full_reg) begin
                        bus_addr_next    = wbuf_addr_reg;
                        bus_wr_data_next = wbuf_data_reg;
                        bus_wr_size_next = wbuf_size_reg;
                    end else begin
                        bus_addr_next    = mem_addr;
                        bus_wr_data_next = mem_wr_data;
                        bus_wr_size_next = store_size;
                    end
                end else if (pick_d) begin
                    state_next         = DREAD;
                    bus_rd_enable_next = 1'b1;
                    bus_addr_next      = mem_addr;
                end else if (imem_rd_enable) begin
                    state_next         = IREAD;
                    bus_rd_enable_next = 1'b1;
                    bus_addr_next      = imem_addr;
                end
            end
            IREAD, DREAD: begin
                if (bus_ready) begin
                    state_next         = IDLE;
                    bus_rd_enable_next = 1'b0;
                end
            end
            DWRITE: begin
                if (bus_ready) begin
                    state_next         = IDLE;
                    bus_wr_enable_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A dropped request (flush) suppresses the ready pulse; the bus op still finishes.
    assign imem_rd_ready = (state_reg == IREAD) && bus_ready && imem_rd_enable;
    assign mem_rd_ready  = (state_reg == DREAD) && bus_ready && mem_rd_enable;
    assign imem_rd_data  = imem_rd_ready ? bus_rd_data : '0;
    assign mem_rd_data   = mem_rd_ready ? bus_rd_data : '0;

    assign wbuf_full     = wbuf_full_reg;
    assign wbuf_ovf      = wbuf_ovf_reg;
    assign bus_addr      = bus_addr_reg;
    assign bus_wr_data   = bus_wr_data_reg;
    assign bus_wr_size   = bus_wr_size_reg;
    assign bus_wr_enable = bus_wr_enable_reg;
    assign bus_rd_enable = bus_rd_enable_reg;

endmodule
